// File: rtl/sram_port_ctrl_pkg.sv
// Shared constants, state type and helpers for the SRAM port-0 controller.
// Build option SRAM_PORT_CTRL_INIT_EN selects the power-up zero-fill sweep.
package sram_port_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_NUM_WMASKS = 4;
   localparam int DEF_RSP_DEPTH  = 2;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   // Width needed to hold an occupancy value in the range 0..depth.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sram_port_ctrl_rsp_fifo.sv
// Read-response FIFO for sram_port_ctrl. Captured SRAM words are queued here
// and presented in order; the head word stays stable until it is popped.
module sram_port_ctrl_rsp_fifo
   import sram_port_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
   input  logic                              clk0,
   input  logic                              rst0_n,
   input  logic                              push,
   input  logic [DATA_WIDTH-1:0]             push_data,
   input  logic                              pop,
   output logic                              valid,
   output logic [DATA_WIDTH-1:0]             rdata,
   output logic [occ_width(RSP_DEPTH)-1:0]   count
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = occ_width(RSP_DEPTH);

   logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk0) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign valid = (count != '0);
   assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_port_ctrl.sv
// Single-port SRAM request/response controller with registered SRAM pins.
// Define SRAM_PORT_CTRL_INIT_EN to zero-fill the whole array after reset.
//
// state | meaning
// INIT  | sweeping zeros into every address, requests blocked, busy=1
// RUN   | serving requests, terminal until reset
module sram_port_ctrl
   import sram_port_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WMASKS = DEF_NUM_WMASKS,
   parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
   input  logic                   clk0,
   input  logic                   rst0_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [NUM_WMASKS-1:0]  req_wmask,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   busy,
   output logic                   sram_csb0,
   output logic                   sram_web0,
   output logic [NUM_WMASKS-1:0]  sram_wmask0,
   output logic [ADDR_WIDTH-1:0]  sram_addr0,
   output logic [DATA_WIDTH-1:0]  sram_din0,
   input  logic [DATA_WIDTH-1:0]  sram_dout0
);

   localparam int CW = occ_width(RSP_DEPTH);
   localparam int OW = CW + 2;

   logic          accept;
   logic          rd_accept;
   logic          pop;
   logic          rd_p1;
   logic          rd_p2;
   logic          run_next;
   logic          ready_next;
   logic [CW-1:0] fifo_count;
   logic [OW-1:0] occ_next;

`ifdef SRAM_PORT_CTRL_INIT_EN
   ctrl_state_t           state;
   logic [ADDR_WIDTH-1:0] init_addr;

   assign run_next = (state == RUN) || (init_addr == '1);
   assign busy     = (state == INIT);
`else
   assign run_next = 1'b1;
   assign busy     = 1'b0;
`endif

   assign accept    = req_valid && req_ready;
   assign rd_accept = accept && !req_we;
   assign pop       = rsp_valid && rsp_ready;

   // Reads owed after this edge: queued words plus reads still in the SRAM
   // pipe. Keeping this below the depth guarantees every capture has a slot.
   assign occ_next   = OW'(fifo_count) + OW'(rd_p2) + OW'(rd_p1)
                     + OW'(rd_accept) - OW'(pop);
   assign ready_next = run_next && (occ_next < OW'(RSP_DEPTH));

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
`ifdef SRAM_PORT_CTRL_INIT_EN
         state       <= INIT;
         init_addr   <= '0;
`endif
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         rd_p1       <= 1'b0;
         rd_p2       <= 1'b0;
         req_ready   <= 1'b0;
      end else begin
         rd_p1     <= rd_accept;
         rd_p2     <= rd_p1;
         req_ready <= ready_next;
         sram_csb0 <= 1'b1;
`ifdef SRAM_PORT_CTRL_INIT_EN
         if (state == INIT) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= 1'b0;
            sram_wmask0 <= '1;
            sram_addr0  <= init_addr;
            sram_din0   <= '0;
            init_addr   <= init_addr + 1'b1;
            if (init_addr == '1) state <= RUN;
         end else if (accept) begin
`else
         if (accept) begin
`endif
            sram_csb0   <= 1'b0;
            sram_web0   <= !req_we;
            sram_wmask0 <= req_wmask;
            sram_addr0  <= req_addr;
            sram_din0   <= req_wdata;
         end
      end
   end

   sram_port_ctrl_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .RSP_DEPTH  (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk0      (clk0),
      .rst0_n    (rst0_n),
      .push      (rd_p2),
      .push_data (sram_dout0),
      .pop       (pop),
      .valid     (rsp_valid),
      .rdata     (rsp_rdata),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural SRAM, array/queue reference model,
// directed scenarios plus a random request mix.
module tb_sram_port_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int MW    = 4;
   localparam int DEPTH = 2;

   logic          clk0;
   logic          rst0_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [MW-1:0] req_wmask;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic          sram_csb0;
   logic          sram_web0;
   logic [MW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0;

   sram_port_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_WMASKS (MW),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk0        (clk0),
      .rst0_n      (rst0_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_wmask   (req_wmask),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .busy        (busy),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0)
   );

   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   function automatic logic [31:0] seed_val(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Synchronous SRAM: inputs sampled on the edge, read data one cycle later.
   logic [DW-1:0] sram_mem [256];
   bit            mem_loaded = 1'b0;

   always @(posedge clk0) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= seed_val(i);
         mem_loaded <= 1'b1;
      end else if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < MW; b++)
               if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
         end else begin
            sram_dout0 <= sram_mem[sram_addr0];
         end
      end
   end

   // Reference model: memory contents and reads owed, in acceptance order.
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_q [$];
   logic          last_web;
   logic [AW-1:0] last_addr;
   logic [MW-1:0] last_mask;
   logic [DW-1:0] last_din;
   int            errors = 0;
   int            checks = 0;
   logic          acc;
   int            got;
   logic [AW-1:0] bp_addr [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_last();
      last_web  = 1'b1;
      last_addr = '0;
      last_mask = '0;
      last_din  = '0;
   endtask

   task automatic reset_checks();
      chk("rst_csb",   32'(sram_csb0),   32'd1);
      chk("rst_web",   32'(sram_web0),   32'd1);
      chk("rst_wmask", 32'(sram_wmask0), 32'd0);
      chk("rst_addr",  32'(sram_addr0),  32'd0);
      chk("rst_din",   sram_din0,        32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata,      32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef SRAM_PORT_CTRL_INIT_EN
      chk("rst_busy", 32'(busy), 32'd1);
`else
      chk("rst_busy", 32'(busy), 32'd0);
`endif
   endtask

   // Called right after reset release; returns at a falling edge with the
   // controller ready to accept.
   task automatic wait_ready();
      int n;
`ifdef SRAM_PORT_CTRL_INIT_EN
      n = 0;
      while (busy && n < 400) begin
         n++;
         if (n == 100) chk("init_ready_low", 32'(req_ready), 32'd0);
         @(posedge clk0); #1;
      end
      chk("init_busy_cycles", 32'(n), 32'd256);
      chk("init_ready_after", 32'(req_ready), 32'd1);
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      last_web  = 1'b0;
      last_addr = 8'hFF;
      last_mask = 4'hF;
      last_din  = '0;
`else
      n = 0;
      chk("busy_const", 32'(busy), 32'd0);
      @(posedge clk0); #1;
      chk("ready_after_rst", 32'(req_ready), 32'd1);
`endif
      @(negedge clk0);
   endtask

   // One clock of stimulus, entered and left at a falling edge.
   task automatic step(input logic v, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rr, output logic accepted);
      req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
      rsp_ready = rr;
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      if (rsp_valid) begin
         if (exp_q.size() == 0) chk("rsp_spurious", 32'(rsp_valid), 32'd0);
         else begin
            chk("rsp_data", rsp_rdata, exp_q[0]);
            if (rr) void'(exp_q.pop_front());
         end
      end
      accepted = v && req_ready;
      if (accepted) begin
         if (we) begin
            for (int b = 0; b < MW; b++)
               if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
         end else begin
            exp_q.push_back(ref_mem[a]);
         end
         last_web = !we; last_addr = a; last_mask = m; last_din = d;
      end
      @(posedge clk0); #1;
      chk("sram_csb",   32'(sram_csb0),   32'(!accepted));
      chk("sram_web",   32'(sram_web0),   32'(last_web));
      chk("sram_addr",  32'(sram_addr0),  32'(last_addr));
      chk("sram_wmask", 32'(sram_wmask0), 32'(last_mask));
      chk("sram_din",   sram_din0,        last_din);
      @(negedge clk0);
   endtask

   task automatic idle(input logic rr);
      logic a;
      step(1'b0, 1'b0, '0, '0, '0, rr, a);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
      idle(1'b1);
      chk("drain_owed", 32'(exp_q.size()), 32'd0);
      chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst0_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
      reset_last();
      repeat (3) @(negedge clk0);
      #1;
      reset_checks();
      rst0_n = 1'b1;
      wait_ready();

      // Reads of the first and last words (zero after the init sweep).
      step(1'b1, 1'b0, '0, 8'h00, '0, 1'b1, acc);
      step(1'b1, 1'b0, '0, 8'hFF, '0, 1'b1, acc);
      drain();

      // Latency: read data appears two edges after the read is accepted.
      step(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, 1'b1, acc);
      step(1'b1, 1'b0, '0, 8'h10, '0, 1'b0, acc);
      chk("lat_read_acc", 32'(acc), 32'd1);
      chk("lat_t0", 32'(rsp_valid), 32'd0);
      idle(1'b0);
      chk("lat_t1", 32'(rsp_valid), 32'd0);
      idle(1'b0);
      chk("lat_t2", 32'(rsp_valid), 32'd1);
      chk("lat_data", rsp_rdata, 32'hDEAD_BEEF);
      drain();

      // Byte-lane merge, then read-after-write on consecutive cycles.
      step(1'b1, 1'b1, 4'hF,    8'h20, 32'h1122_3344, 1'b1, acc);
      step(1'b1, 1'b1, 4'b0101, 8'h20, 32'hAABB_CCDD, 1'b1, acc);
      step(1'b1, 1'b0, '0,      8'h20, '0,            1'b1, acc);
      step(1'b1, 1'b1, 4'hF,    8'h05, 32'h0000_0055, 1'b1, acc);
      step(1'b1, 1'b0, '0,      8'h05, '0,            1'b1, acc);
      step(1'b1, 1'b1, 4'h0,    8'h06, 32'hFFFF_FFFF, 1'b1, acc);
      step(1'b1, 1'b0, '0,      8'h06, '0,            1'b1, acc);
      drain();

      // Backpressure: four reads with the response side stalled at first.
      bp_addr[0] = 8'h10; bp_addr[1] = 8'h20; bp_addr[2] = 8'h05; bp_addr[3] = 8'h06;
      got = 0;
      for (int k = 0; k < 40 && got < 4; k++) begin
         step(1'b1, 1'b0, '0, bp_addr[got], '0, (k >= 8), acc);
         if (acc) got++;
         if (k == 2) chk("bp_ready_low", 32'(req_ready), 32'd0);
         if (k == 5) begin
            chk("bp_full_valid", 32'(rsp_valid), 32'd1);
            chk("bp_held_count", 32'(got), 32'(DEPTH));
         end
      end
      chk("bp_all_issued", 32'(got), 32'd4);
      drain();

      // Random mix over a small address window to provoke hazards.
      for (int k = 0; k < 400; k++)
         step(($urandom % 4) != 0, 1'($urandom), 4'($urandom),
              8'($urandom_range(0, 15)), $urandom, ($urandom % 4) != 0, acc);
      drain();

      // Reset with two reads in flight: nothing may come out afterwards.
      step(1'b1, 1'b0, '0, 8'h03, '0, 1'b1, acc);
      step(1'b1, 1'b0, '0, 8'h04, '0, 1'b1, acc);
      rst0_n = 1'b0;
      #1;
      reset_checks();
      exp_q.delete();
      reset_last();
      for (int i = 0; i < 256; i++) ref_mem[i] = sram_mem[i];
      repeat (2) @(negedge clk0);
      rst0_n = 1'b1;
      wait_ready();
      for (int k = 0; k < 6; k++) begin
         idle(1'b1);
         chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      step(1'b1, 1'b0, '0, 8'h03, '0, 1'b1, acc);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
